avg_result_buffer: RTL and testbench
====================================

// Module: avg_result_buffer
// PURPOSE
//  Downstream consumer of the MAC averaging datapath, clocked in the read (rclk) domain.
//  Captures each average/avg_valid strobe into a small synchronous FIFO.
//  Presents the samples on a ready/valid stream to the next stage.
//  Drops samples on overflow with sticky/counted status; optional peak tracking.
// PARAMETERS
//  WIDTH  8  sample width (matches 2*WIDTH of MAC default WIDTH=4)
//  DEPTH  8  FIFO entries; power of two, >= 2
//  CNT_W  8  width of saturating drop counter
// PORTS
//  clk        in   1               rclk-domain clock; all logic on posedge
//  r_rst_n    in   1               reset, asynchronous assert, active-low
//  avg_in     in   WIDTH           sample (average from MAC)
//  avg_valid  in   1               1-cycle strobe: avg_in valid this cycle
//  out_data   out  WIDTH           head-of-FIFO sample
//  out_valid  out  1               out_data valid
//  out_ready  in   1               consumer accepts when out_valid&&out_ready
//  count      out  $clog2(DEPTH)+1 current occupancy, 0..DEPTH
//  overflow   out  1               sticky: a sample was dropped
//  drop_cnt   out  CNT_W           dropped samples, saturates at all-ones
//  clr_ovf    in   1               sync clear of overflow, drop_cnt (and peak)
//  peak       out  WIDTH           max sample seen (0 when feature compiled out)
// BEHAVIOUR
//  - Reset (r_rst_n=0, async): pointers, count, overflow, drop_cnt, peak = 0; out_valid=0; out_data=0.
//  - Storage: DEPTH x WIDTH regs; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - push = avg_valid && (count<DEPTH || pop); pop = out_valid && out_ready.
//  - First-word fall-through: out_valid = (count!=0); out_data = mem[rd_ptr] when valid, else 0.
//  - Latency: sample strobed on edge N is visible (out_valid=1) after edge N. No same-cycle bypass when empty.
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Full + avg_valid + pop: sample accepted; count stays DEPTH; no drop.
//  - Full + avg_valid, no pop: sample discarded.
//    On discard: overflow<=1; drop_cnt<=drop_cnt+1, saturating at 2^CNT_W-1.
//  - Empty + out_ready: no pop; pointers and count hold.
//  - out_ready with out_valid=0 is ignored; out_data stable while out_valid && !out_ready.
//  - clr_ovf: overflow<=0, drop_cnt<=0 on next edge.
//    Same-cycle drop wins over clear: overflow<=1, drop_cnt<=1.
//  - FIFO contents unaffected by clr_ovf; only r_rst_n empties the FIFO.
//  - Reset mid-stream: FIFO contents are lost and all status is cleared immediately.
//    First strobe after deassert is stored at entry 0.
// CONFIGURATION
//  AVG_PEAK_TRACK_EN defined:
//    - peak <= max(peak, avg_in) on every avg_valid strobe, dropped samples included (unsigned compare).
//    - clr_ovf sets peak <= 0.
//    - Same-cycle clr_ovf + avg_valid: peak <= avg_in.
//  AVG_PEAK_TRACK_EN undefined:
//    - No peak register; peak tied to 0.
//    - Port list is identical in both builds.
// TESTING  (DEPTH=4, WIDTH=8, CNT_W=8 unless noted)
//  1 Strobe 0x11,0x22,0x33 with out_ready=0
//    -> count=3, out_valid=1, out_data=0x11.
//    Then out_ready=1 for 3 cycles -> outputs 0x11,0x22,0x33; count=0; out_valid=0.
//  2 Five strobes 0x01..0x05, out_ready=0
//    -> count=4; 0x05 dropped; overflow=1; drop_cnt=1.
//    Drain -> 0x01..0x04 in order.
//  3 Full FIFO, avg_valid=1 with out_ready=1 same cycle
//    -> no drop; count stays 4; new sample emerges after the 3 older entries.
//  4 CNT_W=2, 6 drops -> drop_cnt saturates at 3.
//    clr_ovf alone -> overflow=0, drop_cnt=0.
//    clr_ovf coincident with a drop -> overflow=1, drop_cnt=1.
//  5 10 push/pop cycles wrapping pointers twice -> data order preserved.
//    Assert r_rst_n=0 mid-stream -> out_valid=0, count=0 immediately.
//  6 AVG_PEAK_TRACK_EN: strobes 0x40,0xF0,0x10 -> peak=0xF0; clr_ovf -> peak=0.
//    Macro undefined -> peak=0 throughout.

Source files
------------

// File: rtl/avg_result_buffer.sv
// rtl/avg_result_buffer.sv - rclk-domain FIFO for MAC averages with drop status; peak tracking under AVG_PEAK_TRACK_EN
module avg_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     r_rst_n,
  input  logic [WIDTH-1:0]         avg_in,
  input  logic                     avg_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         peak
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0]    ONE_C   = CW'(1);
  localparam logic [AW-1:0]    PTR_INC = AW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic push;
  logic pop;
  logic drop;

  // Handshake decode: a full FIFO still accepts a sample when the head leaves this cycle
  always_comb begin
    pop  = (count_q != '0) && out_ready;
    push = avg_valid && ((count_q != FULL_C) || pop);
    drop = avg_valid && (count_q == FULL_C) && !pop;
  end

  // Storage write and pointer/occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = avg_in;
      wr_ptr_d        = wr_ptr_q + PTR_INC;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_INC;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Drop status: a drop in the same cycle as a clear wins and restarts the count at one
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf) begin
        drop_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (drop_cnt_q != CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // FIFO state registers; reset discards contents and all status
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // First-word fall-through output; data forced to zero when nothing is held
  always_comb begin
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    count     = count_q;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
  end

`ifdef AVG_PEAK_TRACK_EN
  logic [WIDTH-1:0] peak_q, peak_d;

  // Peak sees every strobe, including dropped ones; clear with a strobe restarts from that sample
  always_comb begin
    peak_d = peak_q;
    if (avg_valid) begin
      if (clr_ovf || (avg_in > peak_q)) begin
        peak_d = avg_in;
      end
    end else if (clr_ovf) begin
      peak_d = '0;
    end
  end

  // Peak register
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_avg_result_buffer.sv
// tb/tb_avg_result_buffer.sv - scoreboard bench for avg_result_buffer (DEPTH=4; second instance with CNT_W=2)
module tb_avg_result_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             r_rst_n;
  logic [WIDTH-1:0] avg_in;
  logic             avg_valid;
  logic             out_ready;
  logic             clr_ovf;

  logic [WIDTH-1:0] out_data, out_data2;
  logic             out_valid, out_valid2;
  logic [2:0]       count, count2;
  logic             overflow, overflow2;
  logic [7:0]       drop_cnt;
  logic [1:0]       drop_cnt2;
  logic [WIDTH-1:0] peak, peak2;

  avg_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .r_rst_n(r_rst_n), .avg_in(avg_in), .avg_valid(avg_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
    .clr_ovf(clr_ovf), .peak(peak)
  );

  avg_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) u_sat (
    .clk(clk), .r_rst_n(r_rst_n), .avg_in(avg_in), .avg_valid(avg_valid),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .count(count2), .overflow(overflow2), .drop_cnt(drop_cnt2),
    .clr_ovf(clr_ovf), .peak(peak2)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               m_count;
  logic             m_ovf;
  int               m_drop;
  int               m_drop2;
  logic [WIDTH-1:0] m_peak;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted output word is compared against the scoreboard head
  always @(negedge clk) begin
    if (r_rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
      else check("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic check_status(input string tag);
    check({tag, ":count"},     32'(count),     32'(m_count));
    check({tag, ":out_valid"}, 32'(out_valid), 32'(m_count != 0));
    check({tag, ":out_data"},  32'(out_data),  (m_count != 0) ? 32'(exp_q[0]) : 32'h0);
    check({tag, ":overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ":drop_cnt"},  32'(drop_cnt),  32'(m_drop));
    check({tag, ":drop_cnt2"}, 32'(drop_cnt2), 32'(m_drop2));
    check({tag, ":peak"},      32'(peak),      32'(m_peak));
  endtask

  // Called at posedge+1: drive inputs, predict, advance one clock, check status
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rdy,
                      input logic clr, input string tag);
    logic pop_m, push_m, drop_m;
    avg_valid = v; avg_in = d; out_ready = rdy; clr_ovf = clr;
    pop_m  = (m_count != 0) && rdy;
    push_m = v && ((m_count < DEPTH) || pop_m);
    drop_m = v && (m_count == DEPTH) && !pop_m;
    if (push_m) exp_q.push_back(d);
    @(posedge clk); #1;
    m_count = m_count + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    if (drop_m) begin
      m_ovf   = 1'b1;
      m_drop  = clr ? 1 : ((m_drop  == 255) ? 255 : m_drop + 1);
      m_drop2 = clr ? 1 : ((m_drop2 == 3)   ? 3   : m_drop2 + 1);
    end else if (clr) begin
      m_ovf = 1'b0; m_drop = 0; m_drop2 = 0;
    end
`ifdef AVG_PEAK_TRACK_EN
    if (v) m_peak = (clr || d > m_peak) ? d : m_peak;
    else if (clr) m_peak = '0;
`endif
    avg_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    check_status(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_count = 0; m_ovf = 1'b0; m_drop = 0; m_drop2 = 0; m_peak = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    r_rst_n = 1'b0; avg_in = '0; avg_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_status("reset");
    @(negedge clk) r_rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: three strobes held, then drained
    step(1, 8'h11, 0, 0, "t1_fill");
    step(1, 8'h22, 0, 0, "t1_fill");
    step(1, 8'h33, 0, 0, "t1_fill");
    check("t1_head", 32'(out_data), 32'h11);
    step(0, 8'h00, 1, 0, "t1_hold_ready");
    step(0, 8'h00, 1, 0, "t1_drain");
    step(0, 8'h00, 1, 0, "t1_drain");
    step(0, 8'h00, 1, 0, "t1_empty_ready");

    // 2: overflow by one sample
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0, "t2_fill");
    check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
    step(0, 8'h00, 0, 0, "t2_stable");
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "t2_drain");

    // 3: full FIFO with simultaneous push and pop
    step(0, 8'h00, 0, 1, "t3_clear");
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 0, "t3_fill");
    step(1, 8'hA4, 1, 0, "t3_pushpop");
    check("t3_count_full", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "t3_drain");

    // 4: drop counter saturation (CNT_W=2 instance) and clear priority
    for (int i = 0; i < 4; i++) step(1, 8'hB0 + 8'(i), 0, 0, "t4_fill");
    for (int i = 0; i < 6; i++) step(1, 8'hC0 + 8'(i), 0, 0, "t4_drop");
    check("t4_sat", 32'(drop_cnt2), 32'd3);
    step(0, 8'h00, 0, 1, "t4_clr");
    step(1, 8'hD0, 0, 1, "t4_clr_drop");
    check("t4_clr_drop_cnt", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "t4_drain");

    // 5: pointer wrap twice, then reset mid-stream
    for (int i = 0; i < 10; i++) step(1, 8'h60 + 8'(i), 1, 0, "t5_stream");
    step(1, 8'h70, 0, 0, "t5_load");
    step(1, 8'h71, 0, 0, "t5_load");
    r_rst_n = 1'b0;
    #1;
    model_reset();
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_ovf",   32'(overflow), 32'd0);
    @(negedge clk) r_rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 8'h5A, 0, 0, "t5_after_rst");
    step(0, 8'h00, 1, 0, "t5_after_rst_drain");

    // 6: peak tracking (model stays 0 when the feature is compiled out)
    step(1, 8'h40, 1, 0, "t6_peak");
    step(1, 8'hF0, 1, 0, "t6_peak");
    step(1, 8'h10, 1, 0, "t6_peak");
`ifdef AVG_PEAK_TRACK_EN
    check("t6_peak_f0", 32'(peak), 32'hF0);
`else
    check("t6_peak_zero", 32'(peak), 32'h0);
`endif
    step(0, 8'h00, 1, 1, "t6_clr");
    check("t6_peak_clr", 32'(peak), 32'h0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
